// File: rtl/tdc_fine_arbiter.sv
// Round-robin arbiter feeding NCH TDC thermometer codes through one shared fine-encoder core.
// Latency: ch_ack 1 cycle after grant sample, out_valid 1 cycle after ch_ack; 2-cycle result period.
// Backpressure: results held in OUT until out_ready; the next grant issues on the handshake edge.
module tdc_fine_arbiter #(
    parameter int NCH = 4,
    parameter int CW  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH*32-1:0] ch_code,
    output logic [NCH-1:0]    ch_ack,
    input  logic [2:0]        cfg_level,
    output logic [31:0]       enc_in,
    output logic [2:0]        enc_level,
    input  logic [4:0]        enc_bin,
    input  logic              enc_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_data,
    output logic [CW-1:0]     out_ch,
    output logic              out_err,
    output logic [15:0]       err_cnt,
    input  logic              err_cnt_clr
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, ENC, OUT} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   grant_idx;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;
    logic            pick_vld;
    logic            hs;
    logic            grant;
    logic [31:0]     sel_code;

    // Scan offsets from highest to lowest so the nearest requester after last_grant wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = NCH; k >= 1; k--) begin
            cand = IW'((int'(last_grant) + k) % NCH);
            if (ch_req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        sel_code = '0;
        for (int k = 0; k < NCH; k++) begin
            if (pick_idx == IW'(k)) begin
                sel_code = ch_code[32*k +: 32];
            end
        end
    end

    assign hs    = (state == OUT) && out_valid && out_ready;
    assign grant = pick_vld && ((state == IDLE) || hs);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = ENC;
            ENC:     state_nxt = OUT;
            OUT:     if (hs) state_nxt = pick_vld ? ENC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_ack     <= '0;
            enc_in     <= '0;
            enc_level  <= '0;
            grant_idx  <= '0;
            last_grant <= IW'(NCH - 1);
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            out_err    <= 1'b0;
            err_cnt    <= '0;
        end else begin
            ch_ack <= '0;
            if (grant) begin
                ch_ack[pick_idx] <= 1'b1;
                enc_in           <= sel_code;
                enc_level        <= cfg_level;
                grant_idx        <= pick_idx;
                last_grant       <= pick_idx;
            end

            if (state == ENC) begin
                out_valid <= 1'b1;
                out_data  <= enc_err ? 5'd0 : enc_bin;
                out_err   <= enc_err;
                out_ch    <= CW'(grant_idx);
            end else if (hs) begin
                out_valid <= 1'b0;
            end

            // Clear wins over a same-cycle increment.
            if (err_cnt_clr) begin
                err_cnt <= '0;
            end else if ((state == ENC) && enc_err && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tdc_fine_arbiter.sv
module tb_tdc_fine_arbiter;

    localparam int NCH = 4;
    localparam int CW  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    ch_req;
    logic [NCH*32-1:0] ch_code;
    logic [NCH-1:0]    ch_ack;
    logic [2:0]        cfg_level;
    logic [31:0]       enc_in;
    logic [2:0]        enc_level;
    logic [4:0]        enc_bin;
    logic              enc_err;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_data;
    logic [CW-1:0]     out_ch;
    logic              out_err;
    logic [15:0]       err_cnt;
    logic              err_cnt_clr;

    tdc_fine_arbiter #(.NCH(NCH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_code(ch_code), .ch_ack(ch_ack),
        .cfg_level(cfg_level), .enc_in(enc_in), .enc_level(enc_level), .enc_bin(enc_bin),
        .enc_err(enc_err), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_err(out_err), .err_cnt(err_cnt), .err_cnt_clr(err_cnt_clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Fine-encoder core: popcount of a clean thermometer code; bad code or level is an error.
    function automatic logic [5:0] core_res(input logic [31:0] code, input logic [2:0] lvl);
        logic e;
        e = ((code & (code + 32'd1)) != 32'd0) || (lvl == 3'd0) || (lvl > 3'd3);
        return {e, e ? 5'd0 : 5'($countones(code))};
    endfunction

    always_comb begin
        {enc_err, enc_bin} = core_res(enc_in, enc_level);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: expectation pushed at each observed grant, popped on each output handshake.
    typedef struct { int ch; logic [4:0] data; logic err; } sb_t;
    sb_t sbq[$];

    logic [NCH-1:0]    req_q  = '0;
    logic [2:0]        lvl_q  = '0;
    logic [NCH*32-1:0] code_q = '0;
    logic              rstn_q = 1'b0;
    int                model_last = NCH - 1;

    always @(posedge clk) begin
        req_q  <= ch_req;
        lvl_q  <= cfg_level;
        code_q <= ch_code;
        rstn_q <= rst_n;
    end

    function automatic int rr_pick(input logic [NCH-1:0] req, input int last);
        for (int k = 1; k <= NCH; k++) begin
            if (req[(last + k) % NCH]) return (last + k) % NCH;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rstn_q) begin
            model_last = NCH - 1;
            sbq.delete();
        end else begin
            if (ch_ack != '0) begin
                int a;
                logic [5:0] r;
                sb_t e;
                a = 0;
                for (int k = NCH - 1; k >= 0; k--) if (ch_ack[k]) a = k;
                chk("ack_onehot", 64'($onehot(ch_ack)), 64'd1);
                chk("rr_order", 64'(a), 64'(rr_pick(req_q, model_last)));
                model_last = a;
                r = core_res(code_q[a*32 +: 32], lvl_q);
                e.ch = a; e.err = r[5]; e.data = r[4:0];
                sbq.push_back(e);
            end
            if (out_valid && out_ready && rst_n) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    chk("sb_result", {out_ch, out_data, out_err}, {3'(e.ch), e.data, e.err});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (ch_ack == '0 && cyc < 8);
        if (ch_ack == '0) chk("ack_timeout", 64'd1, 64'd0);
    endtask

    task automatic set_codes(input logic [31:0] code);
        for (int k = 0; k < NCH; k++) ch_code[k*32 +: 32] = code;
    endtask

    task automatic txn(input logic [3:0] req, input logic [31:0] code);
        int n;
        set_codes(code);
        ch_req = req;
        wait_ack(n);
        ch_req = '0;
        step();
        step();
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [2:0]  lvl;
        logic [31:0] code;
        int          ch;
        logic [4:0]  data;
        logic        err;
    } vec_t;

    vec_t vt[8];

    initial begin
        int n;
        logic [4:0] hold_data;
        vt[0] = '{4'b0100, 3'd1, 32'h0000_00FF, 2,  5'd8, 1'b0};
        vt[1] = '{4'b1111, 3'd2, 32'h0000_FFFF, 3, 5'd16, 1'b0};
        vt[2] = '{4'b1111, 3'd3, 32'h0FFF_FFFF, 0, 5'd28, 1'b0};
        vt[3] = '{4'b0110, 3'd1, 32'h0000_0007, 1,  5'd3, 1'b0};
        vt[4] = '{4'b0101, 3'd1, 32'h00FF_00FF, 2,  5'd0, 1'b1};
        vt[5] = '{4'b0001, 3'd0, 32'h0000_0001, 0,  5'd0, 1'b1};
        vt[6] = '{4'b1000, 3'd5, 32'h0000_0003, 3,  5'd0, 1'b1};
        vt[7] = '{4'b1010, 3'd3, 32'h7FFF_FFFF, 1, 5'd31, 1'b0};

        rst_n = 1'b0; ch_req = '0; ch_code = '0; cfg_level = 3'd1;
        out_ready = 1'b1; err_cnt_clr = 1'b0;
        step();
        step();
        chk("rst_ack", 64'(ch_ack), 64'd0);
        chk("rst_out", {out_valid, out_data, out_ch, out_err}, 64'd0);
        chk("rst_enc", {enc_in, enc_level}, 64'd0);
        chk("rst_errcnt", 64'(err_cnt), 64'd0);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            set_codes(vt[i].code);
            cfg_level = vt[i].lvl;
            ch_req = vt[i].req;
            wait_ack(n);
            chk("vec_ack_lat", 64'(n), 64'd1);
            chk("vec_ack", 64'(ch_ack), 64'(4'b0001 << vt[i].ch));
            ch_req = '0;
            step();
            chk("vec_out", {out_valid, out_ch, out_data, out_err},
                {1'b1, 3'(vt[i].ch), vt[i].data, vt[i].err});
            step();
            chk("vec_vld_clr", 64'(out_valid), 64'd0);
        end
        chk("errcnt_after_vec", 64'(err_cnt), 64'd3);

        // Backpressure with a second requester waiting and cfg_level changing mid-flight.
        set_codes(32'h0000_003F);
        cfg_level = 3'd1;
        out_ready = 1'b0;
        ch_req = 4'b0100;
        wait_ack(n);
        chk("bp_ack", 64'(ch_ack), 64'b0100);
        cfg_level = 3'd0;
        ch_req = 4'b1000;
        step();
        hold_data = out_data;
        chk("bp_first", {out_valid, out_ch, out_data, out_err}, {1'b1, 3'd2, 5'd6, 1'b0});
        for (int c = 0; c < 10; c++) begin
            step();
            chk("bp_hold", {out_valid, out_ch, out_data, out_err, ch_ack, enc_level},
                {1'b1, 3'd2, hold_data, 1'b0, 4'b0000, 3'd1});
        end
        cfg_level = 3'd2;
        out_ready = 1'b1;
        step();
        chk("bp_regrant", {out_valid, ch_ack}, {1'b0, 4'b1000});
        ch_req = '0;
        step();
        chk("bp_second", {out_valid, out_ch, out_data, out_err}, {1'b1, 3'd3, 5'd6, 1'b0});
        step();

        // Error counter saturation and clear-over-increment.
        force dut.err_cnt = 16'hFFFE;
        #1;
        release dut.err_cnt;
        chk("errcnt_preload", 64'(err_cnt), 64'hFFFE);
        txn(4'b0001, 32'h00FF_00FF);
        chk("errcnt_to_max", 64'(err_cnt), 64'hFFFF);
        txn(4'b0001, 32'h00FF_00FF);
        chk("errcnt_sat", 64'(err_cnt), 64'hFFFF);
        set_codes(32'h00FF_00FF);
        ch_req = 4'b0001;
        wait_ack(n);
        err_cnt_clr = 1'b1;
        ch_req = '0;
        step();
        err_cnt_clr = 1'b0;
        chk("errcnt_clr_wins", {out_err, out_data, err_cnt}, {1'b1, 5'd0, 16'd0});
        step();

        // Reset while in ENC with an errored code in flight.
        set_codes(32'h00FF_00FF);
        cfg_level = 3'd1;
        ch_req = 4'b0101;
        wait_ack(n);
        rst_n = 1'b0;
        step();
        chk("mid_rst_out", {ch_ack, out_valid, out_data, out_ch, out_err}, 64'd0);
        chk("mid_rst_enc", {enc_in, enc_level, err_cnt}, 64'd0);
        step();
        chk("mid_rst_noack", 64'(ch_ack), 64'd0);

        // Continuous requests from all channels after reset release.
        rst_n = 1'b1;
        set_codes(32'h0000_0001);
        ch_req = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            step();
            if (i % 2 == 0)
                chk("cont_grant", {out_valid, ch_ack}, {1'b0, 4'(4'b0001 << ((i / 2) % 4))});
            else
                chk("cont_result", {out_valid, ch_ack, out_ch, out_data},
                    {1'b1, 4'b0000, 3'((i / 2) % 4), 5'd1});
        end
        ch_req = '0;
        step();
        step();
        step();
        chk("sb_drain", 64'(sbq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
